async_fifo_read_stream: RTL and testbench



---
 rtl/async_fifo_read_stream.sv | 108 ++++++++++
 tb/tb_async_fifo_read_stream.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_read_stream.sv
// async_fifo_read_stream: drains the read side of an async FIFO into a valid/ready stream.
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency. Pops are issued on a
// credit basis, so a word is requested only when a buffer slot will be free for it.
module async_fifo_read_stream #(
   parameter int unsigned BITS     = 32,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                read_clk,
   input  logic                read_rst_n,
   input  logic                p_enable,
   input  logic                p_flush,
   output logic                p_fifo_read_en,
   input  logic                p_fifo_read_empty,
   input  logic [BITS-1:0]     p_fifo_read_data,
   output logic                p_out_valid,
   input  logic                p_out_ready,
   output logic [BITS-1:0]     p_out_data,
   output logic [CNT_BITS-1:0] p_count,
   output logic                p_idle
);

   logic [1:0]          r_occ;
   logic                r_inflight;
   logic [BITS-1:0]     r_mem [2];
   logic                r_head;
   logic                r_tail;
   logic [CNT_BITS-1:0] r_count;

   logic [1:0]          w_occ_d;
   logic [2:0]          w_pending;
   logic                w_fire;
   logic                w_pop;
   logic                w_capture;

   // Outputs come straight from registers; valid means the buffer holds a word.
   assign p_out_valid = (r_occ != 2'd0);
   assign p_out_data  = r_mem[r_head];
   assign p_count     = r_count;
   assign p_idle      = (r_occ == 2'd0) && !r_inflight;

   // Handshake decode and credit-based pop issue. A word leaving this cycle frees a slot,
   // hence the ready-to-read_en combinational path. Read enable is held low during reset.
   always_comb begin
      w_fire         = p_out_valid && p_out_ready && !p_flush;
      w_pending      = {1'b0, r_occ} + {2'b00, r_inflight};
      p_fifo_read_en = read_rst_n && p_enable && !p_flush && !p_fifo_read_empty &&
                       (w_pending < (3'd2 + {2'b00, w_fire}));
      w_pop          = p_fifo_read_en && !p_fifo_read_empty;
      // Flush discards the word currently on the FIFO data bus.
      w_capture      = r_inflight && !p_flush;
   end

   // Next buffer occupancy: capture adds, fire removes, flush empties.
   always_comb begin
      w_occ_d = r_occ;
      if (p_flush) begin
         w_occ_d = 2'd0;
      end else if (w_capture && !w_fire) begin
         w_occ_d = r_occ + 2'd1;
      end else if (!w_capture && w_fire) begin
         w_occ_d = r_occ - 2'd1;
      end
   end

   // Occupancy, in-flight flag and head/tail pointers.
   always_ff @(posedge read_clk or negedge read_rst_n) begin
      if (!read_rst_n) begin
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_head     <= 1'b0;
         r_tail     <= 1'b0;
      end else begin
         r_occ      <= w_occ_d;
         r_inflight <= w_pop;
         if (p_flush) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
         end else begin
            if (w_capture) begin
               r_tail <= ~r_tail;
            end
            if (w_fire) begin
               r_head <= ~r_head;
            end
         end
      end
   end

   // Buffer storage: the in-flight word is written to the tail slot.
   always_ff @(posedge read_clk or negedge read_rst_n) begin
      if (!read_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else if (w_capture) begin
         r_mem[r_tail] <= p_fifo_read_data;
      end
   end

   // Delivered-word counter, wrapping naturally at its width.
   always_ff @(posedge read_clk or negedge read_rst_n) begin
      if (!read_rst_n) begin
         r_count <= '0;
      end else if (w_fire) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_async_fifo_read_stream.sv
// Testbench for async_fifo_read_stream: FIFO model, outstanding-word scoreboard,
// table of issue-rule vectors, directed corner sequences and a random soak.
module tb_async_fifo_read_stream;

   localparam int unsigned BITS     = 32;
   localparam int unsigned CNT_BITS = 4;
   localparam int          CNT_MOD  = 1 << CNT_BITS;

   logic                read_clk;
   logic                read_rst_n;
   logic                p_enable;
   logic                p_flush;
   logic                p_fifo_read_en;
   logic                p_fifo_read_empty;
   logic [BITS-1:0]     p_fifo_read_data;
   logic                p_out_valid;
   logic                p_out_ready;
   logic [BITS-1:0]     p_out_data;
   logic [CNT_BITS-1:0] p_count;
   logic                p_idle;

   async_fifo_read_stream #(
      .BITS     (BITS),
      .CNT_BITS (CNT_BITS)
   ) dut (
      .read_clk          (read_clk),
      .read_rst_n        (read_rst_n),
      .p_enable          (p_enable),
      .p_flush           (p_flush),
      .p_fifo_read_en    (p_fifo_read_en),
      .p_fifo_read_empty (p_fifo_read_empty),
      .p_fifo_read_data  (p_fifo_read_data),
      .p_out_valid       (p_out_valid),
      .p_out_ready       (p_out_ready),
      .p_out_data        (p_out_data),
      .p_count           (p_count),
      .p_idle            (p_idle)
   );

   initial read_clk = 1'b0;
   always #5 read_clk = ~read_clk;

   int errors = 0;
   int checks = 0;

   // Reference model: FIFO contents, words popped but not yet delivered, delivered words.
   logic [BITS-1:0] fifo_q [$];
   logic [BITS-1:0] exp_q  [$];
   logic [BITS-1:0] del_q  [$];
   logic [BITS-1:0] saved_q[$];
   logic            model_inflight;
   int              exp_count;

   // Per-test trace of cycles with read_en / valid high.
   int n_ren, n_valid, first_ren, last_ren, first_valid, last_valid, cyc;

   typedef struct packed {
      logic en;
      logic flush;
      logic avail;
      logic exp_ren;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic update_empty();
      p_fifo_read_empty = (fifo_q.size() == 0);
   endtask

   task automatic push(input logic [BITS-1:0] w);
      fifo_q.push_back(w);
      update_empty();
   endtask

   task automatic clear_trace();
      n_ren = 0; n_valid = 0; cyc = 0;
      first_ren = -1; last_ren = -1; first_valid = -1; last_valid = -1;
      del_q.delete();
   endtask

   // One clock cycle: compare at the falling edge, advance the model just after the rising edge.
   task automatic step();
      logic            exp_valid, exp_ren, fire, pop;
      logic [BITS-1:0] w;
      int              pend;
      @(negedge read_clk);
      pend      = exp_q.size();
      exp_valid = (pend - (model_inflight ? 1 : 0)) > 0;
      fire      = exp_valid && p_out_ready && !p_flush;
      exp_ren   = p_enable && !p_flush && (fifo_q.size() != 0) && ((pend - (fire ? 1 : 0)) < 2);
      check("valid", 32'(p_out_valid), 32'(exp_valid));
      check("read_en", 32'(p_fifo_read_en), 32'(exp_ren));
      check("idle", 32'(p_idle), 32'(pend == 0));
      check("count", 32'(p_count), 32'(exp_count % CNT_MOD));
      if (exp_valid) check("data", p_out_data, exp_q[0]);
      pop = p_fifo_read_en && !p_fifo_read_empty;
      if (p_fifo_read_en) begin
         n_ren++;
         if (first_ren < 0) first_ren = cyc;
         last_ren = cyc;
      end
      if (p_out_valid) begin
         n_valid++;
         if (first_valid < 0) first_valid = cyc;
         last_valid = cyc;
      end
      @(posedge read_clk);
      #1;
      if (fire) begin
         del_q.push_back(exp_q.pop_front());
         exp_count++;
      end
      if (p_flush) exp_q.delete();
      model_inflight = pop && !p_flush;
      if (pop) begin
         w = fifo_q.pop_front();
         p_fifo_read_data = w;
         if (!p_flush) exp_q.push_back(w);
      end
      update_empty();
      checks++;
      if (exp_q.size() > 2) begin
         errors++;
         $display("FAIL overflow: outstanding words %0d, limit 2", exp_q.size());
      end
      cyc++;
   endtask

   task automatic do_reset();
      read_rst_n  = 1'b0;
      p_enable    = 1'b0;
      p_flush     = 1'b0;
      p_out_ready = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      model_inflight   = 1'b0;
      exp_count        = 0;
      p_fifo_read_data = '0;
      update_empty();
      repeat (2) @(posedge read_clk);
      #1 read_rst_n = 1'b1;
      clear_trace();
   endtask

   initial begin
      read_rst_n = 1'b1; p_enable = 1'b0; p_flush = 1'b0; p_out_ready = 1'b0;
      p_fifo_read_data = '0; p_fifo_read_empty = 1'b1;
      model_inflight = 1'b0; exp_count = 0;
      clear_trace();
      #1;
      do_reset();

      // Reset values.
      check("rst_valid", 32'(p_out_valid), 32'd0);
      check("rst_data", p_out_data, 32'd0);
      check("rst_count", 32'(p_count), 32'd0);
      check("rst_idle", 32'(p_idle), 32'd1);
      check("rst_read_en", 32'(p_fifo_read_en), 32'd0);

      // Issue rule from idle: read_en = enable && !flush && !empty.
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         @(negedge read_clk);
         p_enable = vecs[i].en;
         p_flush  = vecs[i].flush;
         if (vecs[i].avail) push(32'h100 + i);
         #1;
         check($sformatf("issue_vec%0d", i), 32'(p_fifo_read_en), 32'(vecs[i].exp_ren));
         p_enable = 1'b0;
         p_flush  = 1'b0;
         fifo_q.delete();
         update_empty();
      end

      // Asynchronous reset mid-cycle with a full buffer.
      do_reset();
      for (int i = 0; i < 6; i++) push(32'h50 + i);
      p_enable = 1'b1; p_out_ready = 1'b1;
      repeat (4) step();
      p_out_ready = 1'b0;
      repeat (4) step();
      check("pre_rst_valid", 32'(p_out_valid), 32'd1);
      check("pre_rst_count", 32'(p_count), 32'd2);
      #3 read_rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(p_out_valid), 32'd0);
      check("async_rst_count", 32'(p_count), 32'd0);
      check("async_rst_idle", 32'(p_idle), 32'd1);
      check("async_rst_read_en", 32'(p_fifo_read_en), 32'd0);

      // Single word: pop in cycle 0, valid in cycle 2.
      do_reset();
      push(32'hA5A50001);
      p_enable = 1'b1; p_out_ready = 1'b1;
      repeat (6) step();
      check("single_ren_cycles", n_ren, 1);
      check("single_first_ren", first_ren, 0);
      check("single_valid_cycles", n_valid, 1);
      check("single_first_valid", first_valid, 2);
      check("single_delivered", del_q.size(), 1);
      if (del_q.size() == 1) check("single_word", del_q[0], 32'hA5A50001);
      check("single_count", 32'(p_count), 32'd1);
      check("single_idle", 32'(p_idle), 32'd1);

      // Burst of 8 at full rate.
      do_reset();
      for (int i = 0; i < 8; i++) push(i);
      p_enable = 1'b1; p_out_ready = 1'b1;
      repeat (12) step();
      check("burst_ren_cycles", n_ren, 8);
      check("burst_ren_span", last_ren - first_ren, 7);
      check("burst_valid_cycles", n_valid, 8);
      check("burst_valid_span", last_valid - first_valid, 7);
      check("burst_latency", first_valid - first_ren, 2);
      check("burst_delivered", del_q.size(), 8);
      for (int i = 0; i < 8 && i < del_q.size(); i++) check($sformatf("burst_word%0d", i), del_q[i], i);
      check("burst_count", 32'(p_count), 32'd8);

      // Backpressure: only two pops, head held, then a ragged ready pattern.
      do_reset();
      for (int i = 0; i < 5; i++) push(32'hB0 + i);
      p_enable = 1'b1; p_out_ready = 1'b0;
      repeat (6) step();
      check("bp_ren_cycles", n_ren, 2);
      check("bp_head_data", p_out_data, 32'hB0);
      begin
         logic [6:0] pat;
         pat = 7'b1101101;
         for (int i = 6; i >= 0; i--) begin
            p_out_ready = pat[i];
            step();
         end
      end
      p_out_ready = 1'b1;
      repeat (8) step();
      check("bp_delivered", del_q.size(), 5);
      for (int i = 0; i < 5 && i < del_q.size(); i++) check($sformatf("bp_word%0d", i), del_q[i], 32'hB0 + i);
      check("bp_count", 32'(p_count), 32'd5);

      // Flush with one buffered word and one in flight.
      do_reset();
      push(32'd10); push(32'd11); push(32'd12); push(32'd13);
      p_enable = 1'b1; p_out_ready = 1'b0;
      repeat (2) step();
      check("pre_flush_valid", 32'(p_out_valid), 32'd1);
      check("pre_flush_idle", 32'(p_idle), 32'd0);
      p_flush = 1'b1;
      step();
      check("post_flush_valid", 32'(p_out_valid), 32'd0);
      check("post_flush_idle", 32'(p_idle), 32'd1);
      check("post_flush_count", 32'(p_count), 32'd0);
      p_flush = 1'b0; p_out_ready = 1'b1;
      repeat (8) step();
      check("flush_delivered", del_q.size(), 2);
      if (del_q.size() == 2) begin
         check("flush_word0", del_q[0], 32'd12);
         check("flush_word1", del_q[1], 32'd13);
      end

      // Counter wrap: 17 words under random ready leave the 4-bit counter at 1.
      do_reset();
      saved_q.delete();
      for (int i = 0; i < 17; i++) begin
         logic [BITS-1:0] w;
         w = $urandom;
         saved_q.push_back(w);
         push(w);
      end
      p_enable = 1'b1;
      for (int i = 0; i < 400 && del_q.size() < 17; i++) begin
         p_out_ready = 1'($urandom_range(0, 1));
         step();
      end
      check("wrap_delivered", del_q.size(), 17);
      for (int i = 0; i < 17 && i < del_q.size(); i++) check($sformatf("wrap_word%0d", i), del_q[i], saved_q[i]);
      check("wrap_count", 32'(p_count), 32'd1);

      // Enable dropped with a word in flight: it is delivered, nothing more is popped.
      clear_trace();
      for (int i = 0; i < 3; i++) push(32'hE0 + i);
      p_out_ready = 1'b1;
      step();
      p_enable = 1'b0;
      repeat (6) step();
      check("en_drop_ren_cycles", n_ren, 1);
      check("en_drop_delivered", del_q.size(), 1);
      if (del_q.size() == 1) check("en_drop_word", del_q[0], 32'hE0);
      check("en_drop_count", 32'(p_count), 32'd2);

      // Random soak against the scoreboard.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) push($urandom);
         p_enable    = ($urandom_range(0, 7) != 0);
         p_out_ready = ($urandom_range(0, 3) != 0);
         p_flush     = ($urandom_range(0, 31) == 0);
         step();
      end
      p_flush = 1'b0; p_enable = 1'b1; p_out_ready = 1'b1;
      repeat (40) step();
      check("soak_idle", 32'(p_idle), 32'd1);
      check("soak_count", 32'(p_count), 32'(exp_count % CNT_MOD));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
